// File: rtl/rs_decode_arbiter_if.sv
// Requester, response and decoder-side signals around the shared RS decode engine.
// master = arbiter side, slave = requesters/consumer/decoder side.
interface rs_decode_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int CW_BYTES = 30
);
  localparam int CW  = CW_BYTES * 8;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [CW-1:0]      resp_error_pos;
  logic               resp_with_error;
  logic               resp_timeout;

  logic               dec_en;
  logic               dec_clrn;
  logic [CW-1:0]      dec_data;
  logic               dec_ready;
  logic               dec_done;
  logic [CW-1:0]      dec_error_pos;
  logic               dec_with_error;

  logic               busy;
  logic [15:0]        err_count;
  logic [7:0]         timeout_count;

  modport master (
    input  req_valid, req_data, resp_ready,
    input  dec_ready, dec_done, dec_error_pos, dec_with_error,
    output req_ready, resp_valid, resp_id, resp_error_pos, resp_with_error, resp_timeout,
    output dec_en, dec_clrn, dec_data, busy, err_count, timeout_count
  );

  modport slave (
    output req_valid, req_data, resp_ready,
    output dec_ready, dec_done, dec_error_pos, dec_with_error,
    input  req_ready, resp_valid, resp_id, resp_error_pos, resp_with_error, resp_timeout,
    input  dec_en, dec_clrn, dec_data, busy, err_count, timeout_count
  );
endinterface

// File: rtl/rs_decode_arbiter.sv
// Round-robin sharing of one RS decoder among NREQ requesters, with a watchdog that clears a hung decode.
// Grant to dec_en 1 cycle; result 1 cycle after dec_done (or TIMEOUT+1); resp held until resp_ready, no new grant meanwhile.
module rs_decode_arbiter #(
  parameter int NREQ     = 4,
  parameter int CW_BYTES = 30,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  rs_decode_arbiter_if.master bus
);
  localparam int CW  = CW_BYTES * 8;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state, state_nxt;

  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  winner;
  logic [CW-1:0]   win_data;
  logic            grant;
  logic            wd_expire;
  logic [15:0]     wd_cnt;
  logic [NREQ-1:0] req_ready_q;
  logic [CW-1:0]   dec_data_q;
  logic [CW-1:0]   resp_error_pos_q;
  logic            resp_with_error_q;
  logic            resp_timeout_q;
  logic [15:0]     err_count_q;
  logic [7:0]      timeout_count_q;

  // Scan distances farthest-first so the requester nearest after last_grant overwrites the rest.
  always_comb begin
    winner = '0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && (((int'(last_grant) + k) % NREQ) == i))
          winner = IDW'(i);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i))
        win_data = bus.req_data[i*CW +: CW];
    end
  end

  assign grant     = (state == IDLE) && (|bus.req_valid) && bus.dec_ready;
  assign wd_expire = (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // dec_done beats the watchdog when both land in the same cycle.
  always_comb begin
    state_nxt      = state;
    bus.dec_en     = 1'b0;
    bus.dec_clrn   = 1'b1;
    bus.resp_valid = 1'b0;
    bus.busy       = (state != IDLE);
    unique case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE: begin
        bus.dec_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (bus.dec_done) begin
          state_nxt = RESPOND;
        end else if (wd_expire) begin
          bus.dec_clrn = 1'b0;
          state_nxt    = RESPOND;
        end
      end
      RESPOND: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant        <= IDW'(NREQ - 1);
      cur_id            <= '0;
      wd_cnt            <= '0;
      req_ready_q       <= '0;
      dec_data_q        <= '0;
      resp_error_pos_q  <= '0;
      resp_with_error_q <= 1'b0;
      resp_timeout_q    <= 1'b0;
      err_count_q       <= '0;
      timeout_count_q   <= '0;
    end else begin
      req_ready_q <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            req_ready_q <= NREQ'(1) << winner;
            dec_data_q  <= win_data;
            cur_id      <= winner;
          end
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + 16'd1;
          if (bus.dec_done) begin
            resp_error_pos_q  <= bus.dec_error_pos;
            resp_with_error_q <= bus.dec_with_error;
            resp_timeout_q    <= 1'b0;
            if (bus.dec_with_error && (err_count_q != 16'hFFFF))
              err_count_q <= err_count_q + 16'd1;
          end else if (wd_expire) begin
            resp_error_pos_q  <= '0;
            resp_with_error_q <= 1'b0;
            resp_timeout_q    <= 1'b1;
            if (timeout_count_q != 8'hFF)
              timeout_count_q <= timeout_count_q + 8'd1;
          end
        end
        RESPOND: if (bus.resp_ready) last_grant <= cur_id;
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.dec_data        = dec_data_q;
  assign bus.resp_id         = cur_id;
  assign bus.resp_error_pos  = resp_error_pos_q;
  assign bus.resp_with_error = resp_with_error_q;
  assign bus.resp_timeout    = resp_timeout_q;
  assign bus.err_count       = err_count_q;
  assign bus.timeout_count   = timeout_count_q;
endmodule

// File: tb/tb_rs_decode_arbiter.sv
// Randomized bench for rs_decode_arbiter: a behavioural decoder and round-robin/counter model check every transaction.
module tb_rs_decode_arbiter;
  localparam int NREQ     = 4;
  localparam int CW_BYTES = 30;
  localparam int CW       = CW_BYTES * 8;
  localparam int TIMEOUT  = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs_decode_arbiter_if #(.NREQ(NREQ), .CW_BYTES(CW_BYTES)) bus ();

  rs_decode_arbiter #(.NREQ(NREQ), .CW_BYTES(CW_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total;
  int bad;
  int m_last;
  int m_err;
  int m_to;
  logic [CW-1:0] data_q [NREQ];
  logic [CW-1:0] cap_epos;
  logic          cap_tmo;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] rand_cw();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[CW-1:0];
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] sh;
    for (int k = 1; k <= NREQ; k++) begin
      sh = mask >> ((last + k) % NREQ);
      if (sh[0]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_id"}, bus.resp_id, 0);
    check({tag, "_resp_epos"}, bus.resp_error_pos, 0);
    check({tag, "_resp_werr"}, bus.resp_with_error, 0);
    check({tag, "_resp_tmo"}, bus.resp_timeout, 0);
    check({tag, "_dec_en"}, bus.dec_en, 0);
    check({tag, "_dec_clrn"}, bus.dec_clrn, 1);
    check({tag, "_dec_data"}, bus.dec_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_err_count"}, bus.err_count, 0);
    check({tag, "_tmo_count"}, bus.timeout_count, 0);
  endtask

  // lat = cycles from dec_en to the decoder's done pulse; 0 or > TIMEOUT means the decoder hangs.
  task automatic run_txn(input logic [NREQ-1:0] mask, input int lat, input logic werr, input int bp,
                         input bit hold, input logic [CW-1:0] pat, output int obs);
    int w, k, rv_k, clrn_lows, clrn_k, stray;
    bit tmo;
    logic [1:0] wi;
    obs = -1;
    w   = rr_pick(m_last, mask);
    wi  = 2'(w);
    tmo = (lat < 1) || (lat > TIMEOUT);
    for (int i = 0; i < NREQ; i++) data_q[i] = rand_cw();
    bus.req_data  = {data_q[3], data_q[2], data_q[1], data_q[0]};
    bus.req_valid = mask;
    bus.dec_ready = 1'b1;

    k = 0;
    while (!bus.dec_en && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("grant_lat", k, 1);
    if (!bus.dec_en) return;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs = i;
    check("grant", obs, w);
    check("req_ready", bus.req_ready, 4'b0001 << wi);
    check("dec_data", bus.dec_data, data_q[wi]);
    check("busy", bus.busy, 1);
    if (!hold) bus.req_valid = mask & ~(4'b0001 << wi);

    rv_k = -1; clrn_lows = 0; clrn_k = -1; stray = 0; k = 0;
    while (rv_k < 0 && k < TIMEOUT + 5) begin
      @(negedge clk);
      k++;
      bus.dec_done       = (k == lat);
      bus.dec_with_error = (k == lat) ? werr : 1'($urandom);
      bus.dec_error_pos  = (k == lat) ? pat : rand_cw();
      #1;
      if (!bus.dec_clrn) begin clrn_lows++; clrn_k = k; end
      if (bus.dec_en || (bus.req_ready != 0)) stray++;
      if (bus.resp_valid) rv_k = k;
    end
    bus.dec_done = 1'b0;
    check("resp_lat", rv_k, tmo ? TIMEOUT + 1 : lat + 1);
    check("clrn_lows", clrn_lows, tmo ? 1 : 0);
    if (tmo) check("clrn_at", clrn_k, TIMEOUT);

    if (tmo) m_to = (m_to < 255) ? m_to + 1 : m_to;
    else if (werr) m_err = (m_err < 65535) ? m_err + 1 : m_err;

    cap_epos = bus.resp_error_pos;
    cap_tmo  = bus.resp_timeout;
    for (int b = 0; b <= bp; b++) begin
      check("resp_valid", bus.resp_valid, 1);
      check("resp_id", bus.resp_id, wi);
      check("resp_epos", bus.resp_error_pos, tmo ? '0 : pat);
      check("resp_werr", bus.resp_with_error, tmo ? 1'b0 : werr);
      check("resp_tmo", bus.resp_timeout, tmo);
      check("err_count", bus.err_count, m_err);
      check("tmo_count", bus.timeout_count, m_to);
      if (b < bp) begin
        @(negedge clk);
        bus.dec_done      = 1'($urandom);
        bus.dec_error_pos = rand_cw();
        #1;
        if (bus.dec_en || (bus.req_ready != 0)) stray++;
      end
    end
    check("no_stray_issue", stray, 0);

    @(negedge clk);
    bus.dec_done   = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    bus.resp_ready = 1'b0;
    check("resp_drop", bus.resp_valid, 0);
    m_last = w;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "bench watchdog");
  end

  initial begin
    logic [CW-1:0] pat;
    int g, k, stray;
    total = 0; bad = 0;
    m_last = NREQ - 1; m_err = 0; m_to = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.resp_ready = 1'b0;
    bus.dec_ready = 1'b1; bus.dec_done = 1'b0; bus.dec_error_pos = '0; bus.dec_with_error = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single request with a known error byte
    pat = '0;
    pat[47:40] = 8'h3C;
    run_txn(4'b0100, 40, 1'b1, 0, 1'b0, pat, g);
    check("single_grant", g, 2);
    check("single_byte5", cap_epos[47:40], 8'h3C);
    check("single_errcnt", bus.err_count, 1);

    // Hung decoder, then a normal decode afterwards
    run_txn(4'b0001, 0, 1'b1, 2, 1'b0, rand_cw(), g);
    check("tmo_count1", bus.timeout_count, 1);
    check("tmo_epos0", cap_epos, 0);
    check("tmo_flag", cap_tmo, 1);
    run_txn(4'b0001, 7, 1'b0, 1, 1'b0, rand_cw(), g);
    check("post_tmo_flag", cap_tmo, 0);

    // Done on the last watchdog cycle
    run_txn(4'b0010, TIMEOUT, 1'b1, 0, 1'b0, rand_cw(), g);
    check("race_tmo", cap_tmo, 0);
    check("race_tmo_count", bus.timeout_count, 1);

    // Decoder not ready blocks the grant
    bus.req_valid = 4'b0010;
    bus.dec_ready = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.dec_en || (bus.req_ready != 0) || bus.busy) stray++;
    end
    check("dec_ready_block", stray, 0);
    run_txn(4'b0010, 5, 1'b0, 0, 1'b0, rand_cw(), g);
    check("after_block_grant", g, 1);

    // Long response backpressure with requester 1 waiting
    run_txn(4'b0011, 10, 1'b0, 20, 1'b0, rand_cw(), g);
    check("bp_grant", g, 0);
    run_txn(4'b0010, 3, 1'b1, 0, 1'b0, rand_cw(), g);
    check("bp_pending_grant", g, 1);

    // Asynchronous reset in the middle of a decode
    bus.req_valid = 4'b0100;
    k = 0;
    while (!bus.dec_en && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("rstw_issue", bus.dec_en, 1);
    bus.req_valid = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rstw");
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NREQ - 1; m_err = 0; m_to = 0;
    #1;

    // Fairness with every requester held valid
    for (int i = 0; i < 6; i++) begin
      run_txn(4'b1111, $urandom_range(1, 20), 1'($urandom), 0, 1'b1, rand_cw(), g);
      check("fair_order", g, i % NREQ);
    end

    for (int i = 0; i < 25; i++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 60), 1'($urandom),
              $urandom_range(0, 4), 1'b0, rand_cw(), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
